// File: rtl/fxp_pkg.sv
// ============================================================================
//  Module      : fxp_pkg
//  Description : Shared fixed-point package for the multiplier and divider:
//                state encoding plus width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fxp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CALC  = 3'd2,
        ROUND = 3'd3,
        SIGN  = 3'd4
    } fxp_state_t;

    // Magnitude width: total width minus the sign bit.
    function automatic int fxp_widthu(input int width);
        return width - 1;
    endfunction

    // Most negative value {1,0...0}; has no positive counterpart.
    function automatic logic [63:0] fxp_smallest(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_fixed_if.sv
// ============================================================================
//  Module      : mul_fixed_if
//  Description : start/busy/done/valid/ovf handshake plus operand/result bus
//                shared by the fixed-point multiplier and divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_fixed_if #(
    parameter int WIDTH = 12
);
    logic             start;
    logic             busy;
    logic             done;
    logic             valid;
    logic             ovf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] val;

    modport master (
        output start, a, b,
        input  busy, done, valid, ovf, val
    );

    modport slave (
        input  start, a, b,
        output busy, done, valid, ovf, val
    );
endinterface

`default_nettype wire

// File: rtl/fxp_round_even.sv
// ============================================================================
//  Module      : fxp_round_even
//  Description : Combinational round-half-to-even of a double-width product
//                down by FBITS; flags a result that no longer fits WIDTHU bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_round_even #(
    parameter int WIDTHU = 11,
    parameter int FBITS  = 4
) (
    input  wire logic [2*WIDTHU-1:0] p_i,
    output logic      [WIDTHU-1:0]   r_o,
    output logic                     carry_o
);
    logic [2*WIDTHU:0] w_shift;
    logic [2*WIDTHU:0] w_sum;
    logic              w_guard;
    logic              w_sticky;
    logic              w_inc;

    generate
        if (FBITS == 0) begin : g_no_frac
            assign w_guard  = 1'b0;
            assign w_sticky = 1'b0;
        end else if (FBITS == 1) begin : g_one_frac
            assign w_guard  = p_i[0];
            assign w_sticky = 1'b0;
        end else begin : g_multi_frac
            assign w_guard  = p_i[FBITS-1];
            assign w_sticky = |p_i[FBITS-2:0];
        end
    endgenerate

    assign w_shift = {1'b0, p_i} >> FBITS;
    // Round up above half, or on an exact half when R is odd.
    assign w_inc   = w_guard & (w_shift[0] | w_sticky);
    assign w_sum   = w_shift + {{(2*WIDTHU){1'b0}}, w_inc};
    assign r_o     = w_sum[WIDTHU-1:0];
    assign carry_o = |w_sum[2*WIDTHU:WIDTHU];

endmodule

`default_nettype wire

// File: rtl/mul_fixed.sv
// ============================================================================
//  Module      : mul_fixed
//  Description : Sequential signed fixed-point shift-add multiplier with
//                round-half-to-even. Optional macro MUL_SATURATE_EN saturates
//                computed overflow instead of aborting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FIXED_POINT_BITS
`define FIXED_POINT_BITS 4
`endif

module mul_fixed
    import fxp_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int FBITS = `FIXED_POINT_BITS
) (
    input  wire logic  clk,
    input  wire logic  rst,
    mul_fixed_if.slave bus
);
    localparam int               WIDTHU   = fxp_widthu(WIDTH);
    localparam int               CW       = $clog2(WIDTHU + 1);
    localparam logic [WIDTH-1:0] SMALLEST = WIDTH'(fxp_smallest(WIDTH));
    localparam logic [CW-1:0]    LAST     = CW'(WIDTHU - 1);
    localparam logic [WIDTHU-1:0] ONE_U   = {{(WIDTHU-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    fxp_state_t          state_q, state_d;
    logic [WIDTHU-1:0]   au_q, au_d;
    logic [WIDTHU-1:0]   bu_q, bu_d;
    logic [WIDTHU-1:0]   mul_q, mul_d;
    logic [2*WIDTHU-1:0] acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTHU-1:0]   r_q, r_d;
    logic                sign_q, sign_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic [WIDTH-1:0]    val_q, val_d;

    logic [WIDTHU-1:0]   w_round;
    logic                w_carry;
    logic [2*WIDTHU-1:0] w_au_ext;

    assign w_au_ext = {{WIDTHU{1'b0}}, au_q};

    fxp_round_even #(
        .WIDTHU (WIDTHU),
        .FBITS  (FBITS)
    ) u_round (
        .p_i     (acc_q),
        .r_o     (w_round),
        .carry_o (w_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            au_q    <= '0;
            bu_q    <= '0;
            mul_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            au_q    <= au_d;
            bu_q    <= bu_d;
            mul_q   <= mul_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        au_d    = au_q;
        bu_d    = bu_q;
        mul_d   = mul_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        sign_d  = sign_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        val_d   = val_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    valid_d = 1'b0;
                    if ((bus.a == SMALLEST) || (bus.b == SMALLEST)) begin
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        au_d    = bus.a[WIDTH-1] ? (~bus.a[WIDTHU-1:0] + ONE_U)
                                                 : bus.a[WIDTHU-1:0];
                        bu_d    = bus.b[WIDTH-1] ? (~bus.b[WIDTHU-1:0] + ONE_U)
                                                 : bus.b[WIDTHU-1:0];
                        sign_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        busy_d  = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = INIT;
                    end
                end
            end
            INIT: begin
                acc_d   = '0;
                mul_d   = bu_q;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                if (mul_q[0]) begin
                    acc_d = acc_q + (w_au_ext << cnt_q);
                end
                mul_d = mul_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                r_d     = w_round;
                state_d = SIGN;
                if (w_carry) begin
`ifdef MUL_SATURATE_EN
                    r_d     = '1;
                    ovf_d   = 1'b1;
`else
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = IDLE;
`endif
                end
            end
            SIGN: begin
                if (r_q == '0) begin
                    val_d = '0;
                end else if (sign_q) begin
                    val_d = ~{1'b0, r_q} + ONE_W;
                end else begin
                    val_d = {1'b0, r_q};
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.ovf   = ovf_q;
    assign bus.val   = val_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_fixed.sv
// ============================================================================
//  Module      : tb_mul_fixed
//  Description : Directed vector bench for mul_fixed in Q7.4 (WIDTH=12, FBITS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_fixed;
    localparam int WIDTH = 12;
    localparam int FBITS = 4;
`ifdef MUL_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] val;
        logic        valid;
        logic        ovf;
        int          lat;
        bit          hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_fixed_if #(.WIDTH(WIDTH)) bus ();

    mul_fixed #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic        busy_seen;
    logic [11:0] model_val = 12'h000;
    vec_t        vecs[16];

    function automatic vec_t mk(input logic [11:0] a, input logic [11:0] b,
                                input logic [11:0] val, input logic valid,
                                input logic ovf, input int lat, input bit hold);
        vec_t v;
        v.a = a; v.b = b; v.val = val; v.valid = valid;
        v.ovf = ovf; v.lat = lat; v.hold = hold;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one start and wait (bounded) for done; inj>=0 re-pulses start
    // that many edges after acceptance.
    task automatic run_op(input logic [11:0] a, input logic [11:0] b, input int inj);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 12'h5A5;
        bus.b     = 12'h3C3;
        busy_seen = bus.busy;
        lat       = 0;
        while (!bus.done && lat < 40) begin
            bus.start = (lat == inj);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [11:0] exp_val;
        run_op(v.a, v.b, -1);
        exp_val = v.hold ? model_val : v.val;
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_busy", idx), {31'd0, busy_seen}, {31'd0, (v.lat != 0)});
        check($sformatf("v%0d_val", idx), {20'd0, bus.val}, {20'd0, exp_val});
        check($sformatf("v%0d_valid", idx), {31'd0, bus.valid}, {31'd0, v.valid});
        check($sformatf("v%0d_ovf", idx), {31'd0, bus.ovf}, {31'd0, v.ovf});
        if (v.valid) model_val = v.val;
        @(posedge clk);
        #1;
        check($sformatf("v%0d_done_pulse", idx), {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0]  = mk(12'h018, 12'h020, 12'h030, 1, 0, 14, 0);
        vecs[1]  = mk(12'h001, 12'h008, 12'h000, 1, 0, 14, 0);
        vecs[2]  = mk(12'h003, 12'h008, 12'h002, 1, 0, 14, 0);
        vecs[3]  = mk(12'h001, 12'h009, 12'h001, 1, 0, 14, 0);
        vecs[4]  = mk(12'hFE8, 12'h020, 12'hFD0, 1, 0, 14, 0);
        vecs[5]  = mk(12'hFE8, 12'hFE8, 12'h024, 1, 0, 14, 0);
        vecs[6]  = mk(12'hFFF, 12'h008, 12'h000, 1, 0, 14, 0);
        vecs[7]  = mk(12'hFFD, 12'h008, 12'hFFE, 1, 0, 14, 0);
        vecs[8]  = mk(12'h7FF, 12'h010, 12'h7FF, 1, 0, 14, 0);
        vecs[9]  = mk(12'h010, 12'hFF0, 12'hFF0, 1, 0, 14, 0);
        vecs[10] = SAT ? mk(12'h7FF, 12'h020, 12'h7FF, 1, 1, 14, 0)
                       : mk(12'h7FF, 12'h020, 12'h000, 0, 1, 13, 1);
        // 0x555*0x018 rounds from 2047.5 up to 2048: overflow via rounding carry.
        vecs[11] = SAT ? mk(12'h555, 12'h018, 12'h7FF, 1, 1, 14, 0)
                       : mk(12'h555, 12'h018, 12'h000, 0, 1, 13, 1);
        vecs[12] = SAT ? mk(12'h555, 12'hFE8, 12'h801, 1, 1, 14, 0)
                       : mk(12'h555, 12'hFE8, 12'h000, 0, 1, 13, 1);
        vecs[13] = mk(12'h800, 12'h010, 12'h000, 0, 1, 0, 1);
        vecs[14] = mk(12'h010, 12'h800, 12'h000, 0, 1, 0, 1);
        vecs[15] = mk(12'h018, 12'h020, 12'h030, 1, 0, 14, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {16'd0, bus.busy, bus.done, bus.valid, bus.ovf, bus.val},
              32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply_vec(vecs[i], i);
        end

        // Start re-pulsed while busy must be ignored.
        run_op(12'h018, 12'h020, 3);
        check("busy_start_latency", lat, 14);
        check("busy_start_val", {20'd0, bus.val}, 32'h030);
        check("busy_start_ovf", {31'd0, bus.ovf}, 32'd0);
        @(posedge clk);
        #1;
        seen = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        check("busy_start_no_second_op", seen, 0);

        // Reset in the middle of CALC aborts without done.
        @(negedge clk);
        bus.a     = 12'hFE8;
        bus.b     = 12'h020;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midcalc_reset_outputs",
              {16'd0, bus.busy, bus.done, bus.valid, bus.ovf, bus.val}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("midcalc_reset_no_done", seen, 0);

        run_op(12'h018, 12'h020, -1);
        check("after_reset_latency", lat, 14);
        check("after_reset_val", {20'd0, bus.val}, 32'h030);
        check("after_reset_valid", {31'd0, bus.valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
